// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer.
// The bit-index helper maps combination k onto its captured-table position.
package tt_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NUM_COMBOS = 16;
    localparam int SAMPLE_CNT = 3;

    // Combination 0 lands in the hex MSB of the captured table.
    function automatic logic [3:0] tt_bit_index(input logic [3:0] k);
        return 4'd15 - k;
    endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchroniser for the asynchronous output of the block under test.
module tt_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_sweep_sequencer.sv
// Sweeps all 16 input combinations of a 4-input logic block, majority-votes
// the settled output of each and compares the captured truth table to EXPECTED.
module tt_sweep_sequencer
    import tt_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 8,
    parameter logic [15:0] EXPECTED      = 16'hB744
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dut_out,
    output logic        drv_in1,
    output logic        drv_in2,
    output logic        drv_in3,
    output logic        drv_in4,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured,
    output logic [15:0] mismatch,
    output logic        pass
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t             state;
    logic [3:0]         k;
    logic [CNT_W-1:0]   settle_cnt;
    logic [1:0]         sample_cnt;
    logic [1:0]         samples;
    logic               dut_sync;
    logic               vote;
    logic [15:0]        captured_next;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    tt_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_out),
        .q   (dut_sync)
    );

    // The third sample is taken straight from the synchroniser, so the vote
    // and the table update are formed combinationally in the final SAMPLE cycle.
    always_comb begin
        vote          = majority3(samples[0], samples[1], dut_sync);
        captured_next = captured;
        captured_next[tt_bit_index(k)] = vote;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 4'd0;
            settle_cnt <= '0;
            sample_cnt <= 2'd0;
            samples    <= 2'b00;
            drv_in1    <= 1'b0;
            drv_in2    <= 1'b0;
            drv_in3    <= 1'b0;
            drv_in4    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            captured   <= 16'h0000;
            mismatch   <= 16'h0000;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        captured <= 16'h0000;
                        mismatch <= 16'h0000;
                        pass     <= 1'b0;
                        k        <= 4'd0;
                        busy     <= 1'b1;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    {drv_in1, drv_in2, drv_in3, drv_in4} <= k;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                    sample_cnt <= 2'd0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    samples[sample_cnt[0]] <= dut_sync;
                    if (sample_cnt == 2'(SAMPLE_CNT - 1)) begin
                        captured <= captured_next;
                        if (k == 4'(NUM_COMBOS - 1)) begin
                            mismatch <= captured_next ^ EXPECTED;
                            pass     <= (captured_next == EXPECTED);
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            k     <= k + 4'd1;
                            state <= APPLY;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
